aes_key_expand_last: RTL
========================

Name: aes_key_expand_last

Overview:
- Iterative AES-128 forward key-expansion engine that sits directly upstream of the AES decrypt core.
- Takes the 128-bit cipher key and produces round_key_10, the decrypt core's starting round key.
- Computes one round key per clock (10 cycles) and also streams each intermediate round key with a valid strobe for debug and for encrypt-side reuse.

Parameters:
- NR, 10: number of expansion rounds; fixed for AES-128, other values unsupported.
- KEY_W, 128: key and round-key width in bits.

Ports:
- clk  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous active-low reset.
- key_in  in  128  cipher key; bits [127:120] are key byte 0; w0 = key_in[127:96].
- key_start  in  1  one-cycle request to expand key_in; sampled on clk rising edge.
- busy  out  1  high while expansion is in progress.
- rk_valid  out  1  high for one cycle each time round_key holds a new round key (rounds 1..10).
- round_idx  out  4  round number of the current round_key (1..10); 0 when idle.
- round_key  out  128  current registered round key.
- round_key_10  out  128  final round key; held stable between completions.
- key_ready  out  1  level; high when round_key_10 is valid for the most recent accepted key.

Behaviour:
- Reset (asynchronous):
  - FSM = IDLE.
  - busy = 0, rk_valid = 0, round_idx = 0, key_ready = 0.
  - round_key, round_key_10 and the internal working key register = 0.
- FSM states: IDLE, EXPAND, DONE.
  - IDLE/DONE + key_start=1 at edge E0: latch key_in into the working register, round counter = 1, go to EXPAND; busy=1 and key_ready=0 from E0.
  - EXPAND, at each edge Ei (i=1..10):
    - register next key: w4 = w0 ^ SubWord(RotWord(w3)) ^ {Rcon[i],24'h0}; w5 = w1^w4; w6 = w2^w5; w7 = w3^w6.
    - round_key = next key, round_idx = i, rk_valid = 1 for that cycle.
  - At E10: also load round_key_10, key_ready = 1, busy = 0, go to DONE.
- Latency: round_key_10/key_ready valid 10 cycles after the key_start sampling edge.
- Rcon[1..10] = 01,02,04,08,10,20,40,80,1b,36.
- RotWord rotates bytes left by one: {b1,b2,b3,b0}. SubWord applies the AES S-box per byte.
- key_start while busy: ignored; no restart, no error flag.
- key_start in DONE: accepted as in IDLE; the old round_key_10 stays on the port, but key_ready drops at E0.
- key_in is sampled only at E0; later changes have no effect.
- After E10: rk_valid = 0, round_idx holds 10, round_key holds the round-10 value.
- Reset mid-expansion: immediate abort to IDLE with all outputs at reset values; no partial result is ever flagged valid.
- No combinational path from inputs to outputs; all outputs are registered.

Decomposition:
- Shared package aes_pkg holds:
  - Rcon table as a function of round index.
  - AES_NR = 10.
  - FSM state enum (IDLE, EXPAND, DONE).
  - Byte/word typedefs.
- The S-box comes from the team's shared AES S-box function.
- One sub-module, aes_sub_word: 32-bit combinational SubWord of four S-box lookups, so it can be reused by the 256-bit key variant later.

Test Plan:
- Key 000102030405060708090a0b0c0d0e0f, key_start pulse → key_ready rises exactly 10 cycles later; round_key_10 = 13111d7fe3944a17f307a78b4d2b30c5; exactly 10 rk_valid pulses with round_idx 1..10.
- Key 2b7e151628aed2a6abf7158809cf4f3c → rk_valid with round_idx=1 shows a0fafe1788542cb123a339392a6c7605; round_key_10 = d014f9a8c9ee2589e13f0cc8b6630ca6.
- Key all zeros → round_key_10 = b4ef5bcb3e92e21123e951cf6f8f188e.
- Busy collision: start key 000102..0f, pulse key_start with key 2b7e... at round_idx=4, and change key_in meanwhile → ignored; result is still 13111d7f...4d2b30c5 at cycle 10.
- Reset mid-run: deassert reset_n at round_idx=6 → all outputs 0 and busy=0 immediately (asynchronous). Release and restart with 2b7e... → d014f9a8...b6630ca6 after 10 cycles.
- Back-to-back: key_start in DONE the cycle after completion → key_ready low for 10 cycles while the previous round_key_10 is held; then the new result appears with key_ready=1.

Source files
------------

// File: rtl/aes_pkg.sv
// Shared AES definitions: byte/word types, round count, FSM states,
// round-constant lookup and the forward S-box.
package aes_pkg;

    typedef logic [7:0]  byte_t;
    typedef logic [31:0] word_t;

    localparam int unsigned AES_NR = 10;
    localparam int unsigned KEY_W  = 128;

    typedef enum logic [1:0] {StIdle, StExpand, StDone} state_e;

    // Round constant for rounds 1..10; other indices return 0.
    function automatic byte_t rcon(input logic [3:0] idx);
        unique case (idx)
            4'd1:    rcon = 8'h01;
            4'd2:    rcon = 8'h02;
            4'd3:    rcon = 8'h04;
            4'd4:    rcon = 8'h08;
            4'd5:    rcon = 8'h10;
            4'd6:    rcon = 8'h20;
            4'd7:    rcon = 8'h40;
            4'd8:    rcon = 8'h80;
            4'd9:    rcon = 8'h1b;
            4'd10:   rcon = 8'h36;
            default: rcon = 8'h00;
        endcase
    endfunction

    localparam byte_t SBOX_TBL [256] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5,
        8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0,
        8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc,
        8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a,
        8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0,
        8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b,
        8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85,
        8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5,
        8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17,
        8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88,
        8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c,
        8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9,
        8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6,
        8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e,
        8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94,
        8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68,
        8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    function automatic byte_t sbox(input byte_t x);
        sbox = SBOX_TBL[x];
    endfunction

endpackage

// File: rtl/aes_key_expand_last_if.sv
// Request/result bundle between the key source and the expansion engine.
//   key_in/key_start : key and one-cycle start request (master -> slave)
//   busy, rk_valid, round_idx, round_key : per-round progress (slave -> master)
//   round_key_10, key_ready : final round key and its level valid
interface aes_key_expand_last_if;
    logic [127:0] key_in;
    logic         key_start;
    logic         busy;
    logic         rk_valid;
    logic [3:0]   round_idx;
    logic [127:0] round_key;
    logic [127:0] round_key_10;
    logic         key_ready;

    modport master (
        output key_in, key_start,
        input  busy, rk_valid, round_idx, round_key, round_key_10, key_ready
    );

    modport slave (
        input  key_in, key_start,
        output busy, rk_valid, round_idx, round_key, round_key_10, key_ready
    );
endinterface

// File: rtl/aes_sub_word.sv
// Combinational AES SubWord: S-box applied to each byte of a 32-bit word.
//   word_i : input word
//   word_o : substituted word
module aes_sub_word
    import aes_pkg::*;
(
    input  word_t word_i,
    output word_t word_o
);
    assign word_o = {sbox(word_i[31:24]), sbox(word_i[23:16]),
                     sbox(word_i[15:8]),  sbox(word_i[7:0])};
endmodule

// File: rtl/aes_key_expand_last.sv
// Iterative AES-128 forward key expansion, one round key per clock.
// Produces the last round key (decrypt starting key) and streams rounds 1..10.
//   clk, reset_n : clock and async active-low reset
//   bus          : slave side of aes_key_expand_last_if (key request, progress, result)
module aes_key_expand_last
    import aes_pkg::*;
(
    input logic                 clk,
    input logic                 reset_n,
    aes_key_expand_last_if.slave bus
);
    state_e             state_q;
    logic [KEY_W-1:0]   wkey_q;
    logic [3:0]         rnd_q;
    logic               busy_q;
    logic               rk_valid_q;
    logic [3:0]         round_idx_q;
    logic [KEY_W-1:0]   round_key_q;
    logic [KEY_W-1:0]   round_key_10_q;
    logic               key_ready_q;

    word_t w0, w1, w2, w3, sub_rot, w4, w5, w6, w7;
    logic [KEY_W-1:0] next_key;

    assign {w0, w1, w2, w3} = wkey_q;

    // SubWord(RotWord(w3)); RotWord is a left rotate by one byte.
    aes_sub_word u_sub_word (
        .word_i ({w3[23:0], w3[31:24]}),
        .word_o (sub_rot)
    );

    assign w4       = w0 ^ sub_rot ^ {rcon(rnd_q), 24'h0};
    assign w5       = w1 ^ w4;
    assign w6       = w2 ^ w5;
    assign w7       = w3 ^ w6;
    assign next_key = {w4, w5, w6, w7};

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q        <= StIdle;
            wkey_q         <= '0;
            rnd_q          <= '0;
            busy_q         <= 1'b0;
            rk_valid_q     <= 1'b0;
            round_idx_q    <= '0;
            round_key_q    <= '0;
            round_key_10_q <= '0;
            key_ready_q    <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle, StDone: begin
                    rk_valid_q <= 1'b0;
                    // Restart from DONE keeps the old round_key_10 on the port.
                    if (bus.key_start) begin
                        wkey_q      <= bus.key_in;
                        rnd_q       <= 4'd1;
                        busy_q      <= 1'b1;
                        key_ready_q <= 1'b0;
                        state_q     <= StExpand;
                    end
                end
                StExpand: begin
                    // key_start is deliberately ignored here.
                    wkey_q      <= next_key;
                    round_key_q <= next_key;
                    round_idx_q <= rnd_q;
                    rk_valid_q  <= 1'b1;
                    if (rnd_q == 4'(AES_NR)) begin
                        round_key_10_q <= next_key;
                        key_ready_q    <= 1'b1;
                        busy_q         <= 1'b0;
                        state_q        <= StDone;
                    end else begin
                        rnd_q <= rnd_q + 4'd1;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign bus.busy         = busy_q;
    assign bus.rk_valid     = rk_valid_q;
    assign bus.round_idx    = round_idx_q;
    assign bus.round_key    = round_key_q;
    assign bus.round_key_10 = round_key_10_q;
    assign bus.key_ready    = key_ready_q;
endmodule
